// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end: FSM state encoding,
// RAM command opcodes and the command-word width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  localparam int DATA_W_DEFAULT = 8;

  // Command word = 2-bit opcode on top of the payload.
  function automatic int word_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-in serial-out for RAM read data: load captures the byte, the next
// DATA_W cycles drive it MSB first on miso, then miso returns to 0.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              abort,
  output logic              miso,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     cnt;
  logic              busy;

  // High on the edge that follows the last data bit.
  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      shift_q <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      miso    <= 1'b0;
    end else if (load) begin
      shift_q <= data;
      cnt     <= '0;
      busy    <= 1'b1;
      miso    <= 1'b0;
    end else if (done) begin
      cnt  <= '0;
      busy <= 1'b0;
      miso <= 1'b0;
    end else if (busy) begin
      miso    <= shift_q[DATA_W-1];
      shift_q <= {shift_q[DATA_W-2:0], 1'b0};
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: routes each frame on its first bit, deserialises a
// command word for the RAM and, for read-data frames, returns the RAM byte on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int WORD_W = word_width(DATA_W);
  localparam int CW     = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [CW-1:0] WORD_END = CW'(WORD_W);

  // Handshake: rx_valid and tx_valid are single-cycle strobes with no ready;
  // rx_data is held between strobes, and tx_valid only counts while a
  // READ_DATA frame has finished its word and not yet taken a response.
  state_e            state, state_next;
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-2:0] rx_shift;
  logic [WORD_W-1:0] rx_word;
  logic              rd_addr_received;
  logic              tx_loaded;
  logic              in_rx, shift_en, word_done, tx_load, tx_done;

  assign rx_word = {rx_shift, MOSI};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!SS_n) state_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                  state_next = IDLE;
        else if (!MOSI)            state_next = WRITE;
        else if (rd_addr_received) state_next = READ_DATA;
        else                       state_next = READ_ADD;
      end
      default: if (SS_n) state_next = IDLE;
    endcase
  end

  always_comb begin
    in_rx     = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    shift_en  = in_rx && !SS_n && (bit_cnt != WORD_END);
    word_done = shift_en && (bit_cnt == LAST_BIT);
    tx_load   = (state == READ_DATA) && !SS_n && (bit_cnt == WORD_END) &&
                !tx_loaded && tx_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt          <= '0;
      rx_shift         <= '0;
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      rd_addr_received <= 1'b0;
      tx_loaded        <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (!in_rx || SS_n) begin
        bit_cnt   <= '0;
        tx_loaded <= 1'b0;
      end else begin
        if (shift_en) begin
          bit_cnt  <= bit_cnt + 1'b1;
          rx_shift <= rx_word[WORD_W-2:0];
        end
        if (tx_load) tx_loaded <= 1'b1;
      end
      if (word_done) begin
        rx_data <= rx_word;
        if ((state == READ_ADD) && (rx_word[WORD_W-1:WORD_W-2] == OP_RD_ADDR))
          rd_addr_received <= 1'b1;
      end
      // A read that is cut short by SS_n keeps the address pending.
      if (tx_done && !SS_n) rd_addr_received <= 1'b0;
    end
  end

  spi_tx_serializer #(
    .DATA_W(DATA_W)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .data (tx_data),
    .abort(SS_n),
    .miso (MISO),
    .done (tx_done)
  );

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frames from the test plan followed by random
// frames, each checked against a frame-level model of the SPI protocol.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int DATA_W = 8;
  localparam int WORD_W = DATA_W + 2;
  // First cycle index at which a RAM response can be sampled in a frame:
  // one cycle for SS_n, one for the routing bit, WORD_W for the word.
  localparam int T0 = WORD_W + 2;

  logic              clk = 1'b0;
  logic              rst, MOSI, SS_n, MISO, rx_valid, tx_valid;
  logic [WORD_W-1:0] rx_data;
  logic [DATA_W-1:0] tx_data;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] got_q[$];
  logic              miso_log[$];
  int                n_cmp = 0;
  int                n_err = 0;
  bit                model_flag = 1'b0;
  logic [WORD_W-1:0] model_rx = '0;

  spi_slave #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .MOSI    (MOSI),
    .SS_n    (SS_n),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs already set are consumed by the rising edge, outputs
  // are sampled on the following falling edge.
  task automatic step();
    @(negedge clk);
    if (rx_valid === 1'b1) got_q.push_back(rx_data);
    miso_log.push_back(MISO);
  endtask

  // Drive one frame. d = cycle (after the word) at which the RAM answers,
  // -1 for never; hold = cycles SS_n stays low after the word; rst_c = hold
  // cycle at which reset is asserted, -1 for none; stray puts a tx_valid
  // pulse in the middle of the word.
  task automatic frame(input bit route, input logic [WORD_W-1:0] word, input int nbits,
                       input int d, input logic [DATA_W-1:0] txd, input int hold,
                       input int rst_c, input bit stray);
    int   e;
    bit   did_rst, tx_go, flag0;
    logic expv;
    flag0   = model_flag;
    did_rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    miso_log.delete();

    SS_n = 1'b0; MOSI = 1'($urandom); step();
    MOSI = route; step();
    for (int i = 0; i < nbits; i++) begin
      MOSI     = word[WORD_W-1-i];
      tx_valid = stray && (i == 3);
      tx_data  = DATA_W'($urandom);
      step();
    end
    tx_valid = 1'b0;
    if (nbits == WORD_W) begin
      for (int c = 0; c < hold; c++) begin
        MOSI     = 1'($urandom);
        tx_valid = (c == d) || (d >= 0 && c == d + 11);
        tx_data  = (c == d) ? txd : DATA_W'($urandom);
        if (c == rst_c) begin rst = 1'b1; SS_n = 1'b1; end
        step();
        if (c == rst_c) begin
          rst = 1'b0; tx_valid = 1'b0; did_rst = 1'b1;
          break;
        end
      end
    end
    tx_valid = 1'b0;
    if (!did_rst) begin SS_n = 1'b1; step(); end
    e = miso_log.size() - 1;

    // Frame-level model.
    if (nbits == WORD_W) begin
      exp_q.push_back(word);
      model_rx = word;
    end
    if (route && !flag0 && nbits == WORD_W && word[WORD_W-1:WORD_W-2] == 2'b10)
      model_flag = 1'b1;
    tx_go = route && flag0 && (nbits == WORD_W) && (d >= 0) && (T0 + d < e);
    if (tx_go && (T0 + DATA_W + 1 + d < e)) model_flag = 1'b0;
    if (did_rst) begin model_flag = 1'b0; model_rx = '0; end

    check("rx_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check("rx_word", 32'(got_q[k]), 32'(exp_q[k]));
    for (int i = 0; i <= e; i++) begin
      expv = 1'b0;
      if (tx_go && i >= T0 + 1 + d && i <= T0 + DATA_W + d && i < e)
        expv = txd[T0 + DATA_W + d - i];
      check($sformatf("miso[%0d]", i), 32'(miso_log[i]), 32'(expv));
    end
    check("state_idle", 32'(dut.state), 32'(IDLE));
    check("rd_flag", 32'(dut.rd_addr_received), 32'(model_flag));
    check("rx_hold", 32'(rx_data), 32'(model_rx));
    check("rx_valid_end", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_flag", 32'(dut.rd_addr_received), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;

    // Idle bus: noise on MOSI and tx_valid must not start anything.
    got_q.delete();
    miso_log.delete();
    for (int i = 0; i < 6; i++) begin
      MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = DATA_W'($urandom);
      step();
    end
    tx_valid = 1'b0;
    check("idle_rx_count", got_q.size(), 0);
    for (int i = 0; i < 6; i++) check("idle_miso", 32'(miso_log[i]), 32'd0);
    check("idle_state", 32'(dut.state), 32'(IDLE));

    // Writes.
    frame(1'b0, 10'h005, 10, -1, 8'h00, 4, -1, 1'b0);
    frame(1'b0, 10'h1AA, 10, -1, 8'h00, 3, -1, 1'b1);
    // Read address then read data answered one cycle after rx_valid.
    frame(1'b1, 10'h205, 10, -1, 8'h00, 3, -1, 1'b0);
    frame(1'b1, 10'h300, 10, 1, 8'hAA, 14, -1, 1'b0);
    // Write aborted after 6 bits, then a clean frame.
    frame(1'b0, 10'h0F3, 6, -1, 8'h00, 0, -1, 1'b0);
    frame(1'b0, 10'h0F3, 10, -1, 8'h00, 2, -1, 1'b0);
    // Reset while 8'hFF is shifting out.
    frame(1'b1, 10'h2C1, 10, -1, 8'h00, 3, -1, 1'b0);
    frame(1'b1, 10'h3C0, 10, 0, 8'hFF, 20, 5, 1'b0);
    // RAM never answers; flag survives the frame, then a completed read.
    frame(1'b1, 10'h205, 10, -1, 8'h00, 2, -1, 1'b0);
    frame(1'b1, 10'h3FF, 10, -1, 8'h00, 22, -1, 1'b0);
    frame(1'b1, 10'h300, 10, 2, 8'h5C, 14, -1, 1'b1);
    // Serialisation cut short by SS_n keeps the flag, then a full read.
    frame(1'b1, 10'h2AA, 10, -1, 8'h00, 2, -1, 1'b0);
    frame(1'b1, 10'h355, 10, 0, 8'hC3, 6, -1, 1'b0);
    frame(1'b1, 10'h155, 10, 3, 8'h96, 13, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      bit                r;
      logic [WORD_W-1:0] w;
      int                nb, d, h, rc;
      r = 1'($urandom_range(0, 1));
      w = WORD_W'($urandom_range(0, 1023));
      if (r && $urandom_range(0, 1) == 1) w[WORD_W-1:WORD_W-2] = 2'b10;
      nb = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 9)) : WORD_W;
      d  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 4));
      h  = int'($urandom_range(2, 16));
      rc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, h - 1)) : -1;
      frame(r, w, nb, d, DATA_W'($urandom), h, rc, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
